// File: rtl/vga_stream_gen.sv
// vga_stream_gen: VGA timing source for the RGB stream pipeline.
// Produces one registered 26-bit stream word per pixel clock, plus
// frame/line start strobes and a solid or colour-bar background.
module vga_stream_gen #(
  parameter int unsigned h_active = 640,
  parameter int unsigned h_front  = 16,
  parameter int unsigned h_sync   = 96,
  parameter int unsigned h_back   = 48,
  parameter int unsigned v_active = 480,
  parameter int unsigned v_front  = 10,
  parameter int unsigned v_sync   = 2,
  parameter int unsigned v_back   = 33,
  parameter logic        hs_pol   = 1'b0,
  parameter logic        vs_pol   = 1'b0,
  parameter logic [2:0]  color_bg = 3'b000,
  parameter int unsigned bar_w    = 80
) (
  input  logic        px_clk,
  input  logic        reset,
  input  logic        pattern_sel,
  output logic [25:0] RGBStr_o,
  output logic        frame_start,
  output logic        line_start
);

  localparam int unsigned H_TOTAL = h_active + h_front + h_sync + h_back;
  localparam int unsigned V_TOTAL = v_active + v_front + v_sync + v_back;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_chk
    $error("vga_stream_gen: H_TOTAL or V_TOTAL exceeds 10-bit counter range");
  end
  if (bar_w == 0) begin : g_bar_chk
    $error("vga_stream_gen: bar_w must be non-zero");
  end

  // Comparisons are done at 11 bits so boundaries equal to 1024 stay exact.
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  BAR_LAST  = 10'(bar_w - 1);
  localparam logic [10:0] H_ACT     = 11'(h_active);
  localparam logic [10:0] V_ACT     = 11'(v_active);
  localparam logic [10:0] HS_START  = 11'(h_active + h_front);
  localparam logic [10:0] HS_END    = 11'(h_active + h_front + h_sync);
  localparam logic [10:0] VS_START  = 11'(v_active + v_front);
  localparam logic [10:0] VS_END    = 11'(v_active + v_front + v_sync);
  localparam logic [25:0] RST_WORD  = {23'd0, ~hs_pol, ~vs_pol, 1'b0};

  logic [9:0]  hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [2:0]  bar_q, bar_d;
  logic        mode_q, mode_d;
  logic [25:0] word_q, word_d;
  logic        fs_q, fs_d;
  logic        ls_q, ls_d;

  logic        at_origin;
  logic        mode_eff;
  logic        active;
  logic        hs;
  logic        vs;
  logic [2:0]  rgb;

  // Next-state for counters, bar tracker, mode latch and the output word.
  always_comb begin
    hc_d   = hc_q;
    vc_d   = vc_q;
    cnt_d  = cnt_q;
    bar_d  = bar_q;

    at_origin = (hc_q == '0) && (vc_q == '0);
    // The word at (0,0) already uses the newly sampled mode so the switch
    // lands exactly on the frame boundary.
    mode_eff  = at_origin ? pattern_sel : mode_q;
    mode_d    = mode_eff;

    if (hc_q == H_LAST) begin
      hc_d  = '0;
      vc_d  = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
      cnt_d = '0;
      bar_d = '0;
    end else begin
      hc_d = hc_q + 10'd1;
      if (cnt_q == BAR_LAST) begin
        cnt_d = '0;
        bar_d = bar_q + 3'd1;
      end else begin
        cnt_d = cnt_q + 10'd1;
      end
    end

    active = ({1'b0, hc_q} < H_ACT) && ({1'b0, vc_q} < V_ACT);
    hs     = (({1'b0, hc_q} >= HS_START) && ({1'b0, hc_q} < HS_END)) ? hs_pol : ~hs_pol;
    vs     = (({1'b0, vc_q} >= VS_START) && ({1'b0, vc_q} < VS_END)) ? vs_pol : ~vs_pol;

    if (!active)       rgb = '0;
    else if (mode_eff) rgb = bar_q;
    else               rgb = color_bg;

    word_d = {rgb, hc_q, vc_q, hs, vs, active};
    fs_d   = at_origin;
    ls_d   = (hc_q == '0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      hc_q   <= '0;
      vc_q   <= '0;
      cnt_q  <= '0;
      bar_q  <= '0;
      mode_q <= pattern_sel;
      word_q <= RST_WORD;
      fs_q   <= 1'b0;
      ls_q   <= 1'b0;
    end else begin
      hc_q   <= hc_d;
      vc_q   <= vc_d;
      cnt_q  <= cnt_d;
      bar_q  <= bar_d;
      mode_q <= mode_d;
      word_q <= word_d;
      fs_q   <= fs_d;
      ls_q   <= ls_d;
    end
  end

  assign RGBStr_o    = word_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_stream_gen.sv
// tb_vga_stream_gen: scoreboard bench for vga_stream_gen using a reduced
// raster so several complete frames fit in a short run.
module tb_vga_stream_gen;

  localparam int HA = 64, HF = 4, HSW = 8, HB = 4;
  localparam int VA = 20, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HA + HF + HSW + HB;   // 80
  localparam int VT = VA + VF + VSW + VB;   // 27
  localparam int FRAME = HT * VT;           // 2160
  localparam int BARW = 8;
  localparam logic [2:0] BG = 3'b101;

  typedef struct packed {
    logic [25:0] w;
    logic        fs;
    logic        ls;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        pattern_sel;
  logic [25:0] RGBStr_o;
  logic        frame_start;
  logic        line_start;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  // Reference model state: index of the next word since reset release.
  int   n = 0;
  bit   frame_mode = 1'b0;
  bit   ps_cur = 1'b1;

  vga_stream_gen #(
    .h_active(HA), .h_front(HF), .h_sync(HSW), .h_back(HB),
    .v_active(VA), .v_front(VF), .v_sync(VSW), .v_back(VB),
    .hs_pol(1'b0), .vs_pol(1'b0), .color_bg(BG), .bar_w(BARW)
  ) dut (
    .px_clk(clk),
    .reset(reset),
    .pattern_sel(pattern_sel),
    .RGBStr_o(RGBStr_o),
    .frame_start(frame_start),
    .line_start(line_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected word for raster position (x,y) from the timing rules.
  function automatic exp_t pixel_word(int x, int y, bit bars);
    exp_t e;
    bit act, hsv, vsv;
    int rgb;
    act = (x < HA) && (y < VA);
    hsv = !((x >= HA + HF) && (x < HA + HF + HSW));
    vsv = !((y >= VA + VF) && (y < VA + VF + VSW));
    if (!act)     rgb = 0;
    else if (bars) rgb = (x / BARW) % 8;
    else          rgb = int'(BG);
    e.w  = {3'(rgb), 10'(x), 10'(y), hsv, vsv, act};
    e.fs = (x == 0) && (y == 0);
    e.ls = (x == 0);
    return e;
  endfunction

  // Drive one cycle of inputs and queue the word that edge should produce.
  task automatic step(input bit rst, input bit ps);
    exp_t e;
    int x, y;
    @(negedge clk);
    reset       = rst;
    pattern_sel = ps;
    if (rst) begin
      e.w  = 26'b110;
      e.fs = 1'b0;
      e.ls = 1'b0;
      n    = 0;
    end else begin
      x = n % HT;
      y = (n / HT) % VT;
      if (x == 0 && y == 0) frame_mode = ps;
      e = pixel_word(x, y, frame_mode);
      n++;
    end
    exp_q.push_back(e);
  endtask

  task automatic run_until(input int x, input int y, input bit ps);
    for (int k = 0; k <= FRAME; k++) begin
      if ((n % HT) == x && ((n / HT) % VT) == y) break;
      step(1'b0, ps);
    end
  endtask

  function automatic string chk_name(exp_t e);
    if (!e.fs && !e.ls && e.w == 26'b110) return "reset_word";
    if (e.fs) return "frame_origin";
    if (e.ls) return "line_start";
    return "pixel";
  endfunction

  // Monitor: every edge yields one word; compare it against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if ({RGBStr_o, frame_start, line_start} === e) passed++;
        else $display("FAIL %s got word=%h fs=%b ls=%b expected word=%h fs=%b ls=%b",
                      chk_name(e), RGBStr_o, frame_start, line_start, e.w, e.fs, e.ls);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    pattern_sel = 1'b1;

    // Reset hold with bar mode selected, then a full bar frame plus wrap.
    repeat (5) step(1'b1, 1'b1);
    repeat (FRAME + 200) step(1'b0, 1'b1);

    // Drop to solid mid-frame: bars finish this frame, solid next frame.
    run_until(0, 5, 1'b1);
    run_until(0, 0, 1'b0);
    run_until(0, 12, 1'b0);
    // Back to bars mid-frame: the rest of this frame stays solid.
    run_until(0, 0, 1'b1);
    repeat (FRAME / 2) step(1'b0, 1'b1);

    // Single-cycle reset in the middle of a frame.
    run_until(30, 15, 1'b1);
    step(1'b1, 1'b1);
    repeat (300) step(1'b0, 1'b1);

    // Random mode flips and occasional short resets.
    ps_cur = 1'b1;
    repeat (6000) begin
      if ($urandom_range(299) == 0) ps_cur = ~ps_cur;
      if ($urandom_range(1999) == 0) begin
        repeat ($urandom_range(3, 1)) step(1'b1, ps_cur);
      end
      step(1'b0, ps_cur);
    end

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain got pending=%0d expected pending=0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_stream_gen.md
# vga_stream_gen

Source stage of the RGB stream pipeline. It generates 640x480@60 VGA timing from the pixel clock and packs it into the 26-bit RGB stream word consumed by the character/overlay stages (`RGBStr_i` of the first overlay). It also provides a background fill, either solid colour or 8 vertical colour bars, and frame/line start strobes for downstream sequencers.

## Interface
- `h_active`, 640: visible pixels per line.
- `h_front`, 16: horizontal front porch, pixels.
- `h_sync`, 96: horizontal sync width, pixels.
- `h_back`, 48: horizontal back porch, pixels.
- `v_active`, 480: visible lines per frame.
- `v_front`, 10: vertical front porch, lines.
- `v_sync`, 2: vertical sync width, lines.
- `v_back`, 33: vertical back porch, lines.
- `hs_pol`, 1'b0: HS level during sync (0 = active-low).
- `vs_pol`, 1'b0: VS level during sync.
- `color_bg`, 3'b000: solid background colour {B,G,R}.
- `bar_w`, 80: colour bar width, pixels.

Ports:
- `px_clk`  in  1  pixel clock (25 MHz nominal).
- `reset`  in  1  synchronous, active-high reset.
- `pattern_sel`  in  1  0 = solid `color_bg`, 1 = colour bars.
- `RGBStr_o`  out  26  stream word. [0] Active, [1] VS, [2] HS, [12:3] YC, [22:13] XC, [23] R, [24] G, [25] B.
- `frame_start`  out  1  high for the word carrying XC=0, YC=0.
- `line_start`  out  1  high for every word carrying XC=0.

## Operation
- Internal counters:
  - `hc`: 0..H_TOTAL-1, with H_TOTAL = sum of the h_* parameters (800).
  - `vc`: 0..V_TOTAL-1 (525).
  - `hc` wraps to 0 after H_TOTAL-1; `vc` increments only on that wrap, and wraps to 0 after V_TOTAL-1.
- Both counters are 10 bits wide. An elaboration check fails if H_TOTAL or V_TOTAL exceeds 1024.
- Each cycle the output register is loaded from the current counters:
  - XC=`hc`, YC=`vc`.
  - Active = (`hc` < h_active) && (`vc` < v_active).
  - HS = `hs_pol` when h_active+h_front ≤ `hc` < h_active+h_front+h_sync (656..751); `~hs_pol` otherwise.
  - VS = `vs_pol` when v_active+v_front ≤ `vc` < v_active+v_front+v_sync (490..491); `~vs_pol` otherwise.
- RGB rules:
  - When Active=0, RGB = 3'b000 in both modes.
  - Solid mode, Active=1: RGB = `color_bg`.
  - Bar mode, Active=1: RGB = bar index `b`, where `b` = floor(`hc`/`bar_w`) mod 8.
  - `b` comes from a sequential bar counter, not a divider. The in-bar pixel count resets to 0 at `hc`=0. When the count reaches `bar_w`-1 it returns to 0 and `b` increments. `b` wraps 7→0, and is forced to 0 whenever `hc`=0.
- `pattern_sel` is sampled into an internal mode register only when `hc`=0 and `vc`=0. A mode change therefore takes effect at the next frame boundary and never tears a frame.
- `frame_start` and `line_start` are registered together with `RGBStr_o` and are always aligned to the same word.

## Timing
- Reset (`reset`=1 at a clock edge) sets:
  - `hc`=0, `vc`=0, bar counters 0.
  - Mode register = `pattern_sel` at that edge.
  - `RGBStr_o` = all zero except HS=`~hs_pol` and VS=`~vs_pol`.
  - `frame_start`=0, `line_start`=0.
- Reset asserted mid-frame takes effect at the next edge, overriding all counting. No partial-line recovery is attempted.
- Latency: the first edge with `reset`=0 loads the word for (0,0) with `frame_start`=1 and `line_start`=1. Pixel (x,y) appears on edge y·800+x+1 after reset release. One word is produced per `px_clk`, with no stall and no gaps.
- Frame period is 420000 cycles. `frame_start` pulses exactly once per frame, one cycle wide. `line_start` pulses every 800 cycles.
- Simultaneous `hc` and `vc` wrap (799,524): the next word is (0,0) with `frame_start`=1.

## Test plan
- **Reset release:** hold `reset` 5 cycles, release. The first word must be XC=0, YC=0, Active=1, HS=1, VS=1, `frame_start`=1, `line_start`=1.
- **Horizontal timing:** run 2 lines.
  - HS=0 for exactly 96 consecutive words, XC 656..751.
  - Active=1 for XC 0..639 only.
  - `line_start` every 800 cycles.
- **Vertical timing and frame wrap:** run 1 full frame.
  - VS=0 for YC 490..491 (1600 words).
  - The word after (799,524) is (0,0) with `frame_start`=1.
  - `frame_start` count per frame is 1; period is 420000 cycles.
- **Bar pattern:** `pattern_sel`=1 from reset.
  - At YC=10: RGB=0 for XC 0..79, 1 at XC=80, 7 for XC 560..639, and 0 at XC 640..799 (blanking).
- **Solid mode with mid-frame mode change:** `color_bg`=3'b101, `pattern_sel`=0.
  - All active words have RGB=5.
  - Toggle `pattern_sel` to 1 at YC=200: the remainder of the frame stays RGB=5, and bars start at the next (0,0).
- **Mid-frame reset:** assert `reset` at XC=300, YC=300 for 1 cycle.
  - The next word is the reset word.
  - The following word is (0,0) with `frame_start`=1.
